// File: rtl/dmx8_4bits_reg.sv
// ============================================================================
// Module   : dmx8_4bits_reg
// Purpose  : Registered 1:8 demux for 4-bit words with per-channel valid
//            flags, read-acknowledge, round-robin pointer and sticky overflow.
//            Optional macro DMX8_OVERWRITE_EN: writes to unread channels
//            replace the data (still flagging ovf) instead of being dropped.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmx8_4bits_reg #(
  parameter logic [3:0] RST_VAL = 4'b0000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] d,
  input  logic       wr,
  input  logic       s2,
  input  logic       s1,
  input  logic       s0,
  input  logic       auto,
  input  logic [7:0] rd,
  input  logic       clr_ovf,
  output logic [3:0] y0,
  output logic [3:0] y1,
  output logic [3:0] y2,
  output logic [3:0] y3,
  output logic [3:0] y4,
  output logic [3:0] y5,
  output logic [3:0] y6,
  output logic [3:0] y7,
  output logic [7:0] vld,
  output logic [2:0] ptr,
  output logic       ovf
);

  logic [7:0][3:0] y_q, y_d;
  logic [7:0]      vld_q, vld_d;
  logic [2:0]      ptr_q, ptr_d;
  logic            ovf_q, ovf_d;

  logic [2:0] w_ch;
  logic       w_busy;
  logic       w_collide;
  logic       w_accept;

  assign w_ch      = auto ? ptr_q : {s2, s1, s0};
  // A channel is busy when it still holds unread data not being read this cycle.
  assign w_busy    = vld_q[w_ch] & ~rd[w_ch];
  assign w_collide = wr & w_busy;

`ifdef DMX8_OVERWRITE_EN
  assign w_accept  = wr;
`else
  assign w_accept  = wr & ~w_busy;
`endif

  always_comb begin
    y_d   = y_q;
    vld_d = vld_q & ~rd;
    ptr_d = ptr_q;
    ovf_d = ovf_q;
    if (clr_ovf) begin
      ovf_d = 1'b0;
    end
    // Setting overflow takes priority over a clear on the same edge.
    if (w_collide) begin
      ovf_d = 1'b1;
    end
    if (w_accept) begin
      y_d[w_ch]   = d;
      vld_d[w_ch] = 1'b1;
      if (auto) begin
        ptr_d = ptr_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      y_q   <= {8{RST_VAL}};
      vld_q <= 8'h00;
      ptr_q <= 3'd0;
      ovf_q <= 1'b0;
    end else begin
      y_q   <= y_d;
      vld_q <= vld_d;
      ptr_q <= ptr_d;
      ovf_q <= ovf_d;
    end
  end

  assign y0  = y_q[0];
  assign y1  = y_q[1];
  assign y2  = y_q[2];
  assign y3  = y_q[3];
  assign y4  = y_q[4];
  assign y5  = y_q[5];
  assign y6  = y_q[6];
  assign y7  = y_q[7];
  assign vld = vld_q;
  assign ptr = ptr_q;
  assign ovf = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_dmx8_4bits_reg.sv
// ============================================================================
// Module   : tb_dmx8_4bits_reg
// Purpose  : Directed self-checking bench for dmx8_4bits_reg.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmx8_4bits_reg;

  logic       clk;
  logic       reset_n;
  logic [3:0] d;
  logic       wr;
  logic       s2, s1, s0;
  logic       auto;
  logic [7:0] rd;
  logic       clr_ovf;
  logic [3:0] y0, y1, y2, y3, y4, y5, y6, y7;
  logic [7:0] vld;
  logic [2:0] ptr;
  logic       ovf;

  int n_tests;
  int n_fail;

  dmx8_4bits_reg #(.RST_VAL(4'b0000)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (d),
    .wr      (wr),
    .s2      (s2),
    .s1      (s1),
    .s0      (s0),
    .auto    (auto),
    .rd      (rd),
    .clr_ovf (clr_ovf),
    .y0      (y0),
    .y1      (y1),
    .y2      (y2),
    .y3      (y3),
    .y4      (y4),
    .y5      (y5),
    .y6      (y6),
    .y7      (y7),
    .vld     (vld),
    .ptr     (ptr),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] y_of(input int i);
    case (i)
      0: return y0;
      1: return y1;
      2: return y2;
      3: return y3;
      4: return y4;
      5: return y5;
      6: return y6;
      default: return y7;
    endcase
  endfunction

  logic [3:0] y0_exp;
  logic [2:0] ptr_exp;
  logic [3:0] y3_exp;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    d = 4'h0; wr = 1'b0; {s2, s1, s0} = 3'b000;
    auto = 1'b0; rd = 8'h00; clr_ovf = 1'b0;

    step(); step();
    #2 reset_n = 1'b1;
    step();
    check("rst_vld", {24'h0, vld}, 32'h00);
    check("rst_ptr", {29'h0, ptr}, 32'h0);
    check("rst_ovf", {31'h0, ovf}, 32'h0);
    check("rst_y0",  {28'h0, y0}, 32'h0);

    // Manual write to channel 5
    auto = 1'b0; {s2, s1, s0} = 3'b101; d = 4'hA; wr = 1'b1;
    step();
    wr = 1'b0;
    check("man_y5",  {28'h0, y5}, 32'hA);
    check("man_vld", {24'h0, vld}, 32'h20);
    check("man_ptr", {29'h0, ptr}, 32'h0);
    check("man_y4",  {28'h0, y4}, 32'h0);

    // Asynchronous reset mid-cycle while a write is pending
    {s2, s1, s0} = 3'b000; d = 4'hF; wr = 1'b1;
    #3 reset_n = 1'b0;
    #1;
    check("arst_y5",  {28'h0, y5}, 32'h0);
    check("arst_vld", {24'h0, vld}, 32'h00);
    check("arst_ovf", {31'h0, ovf}, 32'h0);
    step();
    wr = 1'b0;
    #2 reset_n = 1'b1;
    step();
    check("arst_lost_vld", {24'h0, vld}, 32'h00);
    check("arst_lost_y0",  {28'h0, y0}, 32'h0);

    // Round-robin fill of all eight channels
    auto = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d = 4'(i + 1); wr = 1'b1;
      step();
    end
    wr = 1'b0;
    check("rr_vld", {24'h0, vld}, 32'hFF);
    check("rr_ptr", {29'h0, ptr}, 32'h0);
    check("rr_ovf", {31'h0, ovf}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("rr_y%0d", i), {28'h0, y_of(i)}, 32'(i + 1));
    end

    // Ninth write onto a full set of channels
    d = 4'h9; wr = 1'b1;
    step();
    wr = 1'b0;
`ifdef DMX8_OVERWRITE_EN
    y0_exp = 4'h9; ptr_exp = 3'd1;
`else
    y0_exp = 4'h1; ptr_exp = 3'd0;
`endif
    check("ninth_ovf", {31'h0, ovf}, 32'h1);
    check("ninth_y0",  {28'h0, y0}, {28'h0, y0_exp});
    check("ninth_ptr", {29'h0, ptr}, {29'h0, ptr_exp});
    check("ninth_vld", {24'h0, vld}, 32'hFF);

    // Read-acknowledge on channels 0 and 7
    rd = 8'h81;
    step();
    rd = 8'h00;
    check("rdclr_vld", {24'h0, vld}, 32'h7E);
    check("rdclr_y0",  {28'h0, y0}, {28'h0, y0_exp});
    check("rdclr_y7",  {28'h0, y7}, 32'h8);

    // Rejected (or overwritten) write with simultaneous clr_ovf: set wins
    auto = 1'b0; {s2, s1, s0} = 3'b011; d = 4'hC; wr = 1'b1; clr_ovf = 1'b1;
    step();
    wr = 1'b0;
`ifdef DMX8_OVERWRITE_EN
    y3_exp = 4'hC;
`else
    y3_exp = 4'h4;
`endif
    check("clrpri_ovf", {31'h0, ovf}, 32'h1);
    check("clrpri_y3",  {28'h0, y3}, {28'h0, y3_exp});
    step();
    clr_ovf = 1'b0;
    check("clr_ovf", {31'h0, ovf}, 32'h0);

    // Simultaneous read and write on channel 3: write wins
    d = 4'h6; wr = 1'b1; rd = 8'h08;
    step();
    wr = 1'b0; rd = 8'h00;
    check("rw_y3",  {28'h0, y3}, 32'h6);
    check("rw_vld", {24'h0, vld}, 32'h7E);
    check("rw_ovf", {31'h0, ovf}, 32'h0);

    // Read of an empty channel has no effect
    rd = 8'h01;
    step();
    rd = 8'h00;
    check("rdempty_vld", {24'h0, vld}, 32'h7E);

    // Manual write to empty channel 0 leaves the pointer alone
    {s2, s1, s0} = 3'b000; d = 4'h5; wr = 1'b1;
    step();
    wr = 1'b0;
    check("man0_y0",  {28'h0, y0}, 32'h5);
    check("man0_vld", {24'h0, vld}, 32'h7F);
    check("man0_ptr", {29'h0, ptr}, {29'h0, ptr_exp});

    // Auto write with all channels acknowledged: accepted at ptr, ptr advances
    auto = 1'b1; d = 4'h7; wr = 1'b1; rd = 8'hFF;
    step();
    wr = 1'b0; rd = 8'h00;
    check("auto_ptr", {29'h0, ptr}, {29'h0, 3'(ptr_exp + 3'd1)});
    check("auto_vld", {24'h0, vld}, {24'h0, 8'(8'h01 << ptr_exp)});
    check("auto_y",   {28'h0, y_of(int'(ptr_exp))}, 32'h7);
    check("auto_ovf", {31'h0, ovf}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
